// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core: multi-cycle RV32I/RV32E subset core sharing one instruction/data memory port
// Ports: clk, rst (sync, active-high); mem_req/mem_wr/mem_addr/wr_data out and rd_data/mem_ready in form
// the shared memory port; PC is the executing instruction address; halted flags an illegal-instruction
// stop; instret counts retired instructions.
module rv_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int NUM_REGS = 32,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic [31:0]          mem_addr,
  output logic [31:0]          wr_data,
  input  logic [31:0]          rd_data,
  input  logic                 mem_ready,
  output logic [31:0]          PC,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);
  localparam logic [INSTRET_W-1:0] ONE = INSTRET_W'(1);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_n;
  logic [31:0] ir, rs1_v, rs2_v, imm, res, pc, imm_dec, op2, alu;
  logic [31:0] rf [NUM_REGS];
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic is_r, is_i, is_lw, is_sw, is_beq, is_jal, alu_ok, bad_rd, bad_rs1, bad_rs2, legal;
  assign op = ir[6:0];
  assign rd = ir[11:7];
  assign f3 = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7 = ir[31:25];
  assign is_r = op == 7'b0110011;
  assign is_i = op == 7'b0010011;
  assign is_lw = op == 7'b0000011 && f3 == 3'b010;
  assign is_sw = op == 7'b0100011 && f3 == 3'b010;
  assign is_beq = op == 7'b1100011 && f3 == 3'b000;
  assign is_jal = op == 7'b1101111;
  assign alu_ok = f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
  assign bad_rd = {1'b0, rd} >= NR;
  assign bad_rs1 = {1'b0, rs1} >= NR;
  assign bad_rs2 = {1'b0, rs2} >= NR;
  // register indices are only checked where the format actually uses that field
  assign legal = is_r ? alu_ok && (f7 == 7'b0 || (f7 == 7'b0100000 && f3 == 3'b000)) && !bad_rd && !bad_rs1 && !bad_rs2
               : is_i ? alu_ok && !bad_rd && !bad_rs1
               : is_lw ? !bad_rd && !bad_rs1
               : is_sw || is_beq ? !bad_rs1 && !bad_rs2
               : is_jal && !bad_rd;
  assign imm_dec = is_sw ? {{20{ir[31]}}, ir[31:25], ir[11:7]}
                 : is_beq ? {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0}
                 : is_jal ? {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0}
                 : {{20{ir[31]}}, ir[31:20]};
  assign op2 = is_r ? rs2_v : imm;
  assign alu = f3 == 3'b111 ? rs1_v & op2
             : f3 == 3'b110 ? rs1_v | op2
             : f3 == 3'b100 ? rs1_v ^ op2
             : f3 == 3'b010 ? {31'b0, $signed(rs1_v) < $signed(op2)}
             : is_r && f7[5] ? rs1_v - op2 : rs1_v + op2;
  assign mem_req = state == FETCH || state == MEM;
  assign mem_wr = state == MEM && is_sw;
  assign mem_addr = (state == FETCH ? pc : res) & ~32'd3;
  assign wr_data = rs2_v;
  assign PC = pc;
  assign halted = state == HALT;
  always_ff @(posedge clk) state <= rst ? FETCH : state_n;
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = mem_ready ? DECODE : FETCH;
      DECODE:  state_n = legal ? EXEC : HALT;
      EXEC:    state_n = is_beq ? FETCH : (is_lw || is_sw) ? MEM : WB;
      MEM:     state_n = mem_ready ? (is_sw ? FETCH : WB) : MEM;
      WB:      state_n = FETCH;
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      instret <= '0;
      ir <= '0;
      rs1_v <= '0;
      rs2_v <= '0;
      imm <= '0;
      res <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) ir <= rd_data;
        DECODE: begin
          // x0 is never written, so its entry always reads zero
          rs1_v <= rf[rs1[AW-1:0]];
          rs2_v <= rf[rs2[AW-1:0]];
          imm <= imm_dec;
        end
        EXEC: begin
          if (is_beq) begin
            pc <= rs1_v == rs2_v ? pc + imm : pc + 32'd4;
            instret <= instret + ONE;
          end else if (is_jal) begin
            res <= pc + 32'd4;
            pc <= pc + imm;
          end else res <= is_lw || is_sw ? rs1_v + imm : alu;
        end
        MEM: if (mem_ready) begin
          if (is_sw) begin
            pc <= pc + 32'd4;
            instret <= instret + ONE;
          end else res <= rd_data;
        end
        WB: begin
          if (rd != 5'd0) rf[rd[AW-1:0]] <= res;
          if (!is_jal) pc <= pc + 32'd4;
          instret <= instret + ONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_multicycle_core.sv
// tb_rv_multicycle_core: directed and random-program checks of rv_multicycle_core against an ISA-level model
module tb_rv_multicycle_core;
  logic clk = 0, rst = 1;
  logic mem_req, mem_wr, mem_ready, halted;
  logic [31:0] mem_addr, wr_data, rd_data, pc, instret;
  logic req16, wr16, halted16;
  logic [31:0] addr16, wd16, rd16, pc16, ir16;
  logic [31:0] mem [256];
  logic [31:0] mm [256];
  int wcnt = 0, wait_n = 0, fixed_wait = 0, w8 = 0, m_cyc = 0;
  bit stall_wr = 0;
  int checks = 0, errors = 0;
  logic hold_p = 0;
  logic [95:0] hold_v;
  logic [31:0] st_a[$], st_d[$], m_sa[$], m_sd[$];
  logic [31:0] m_pc, m_ret;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_op(input logic [6:0] f7, input int rs2, input int rs1, input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_op(input int imm, input int rs1, input logic [2:0] f3, input int rd, input logic [6:0] op);
    return {12'(imm), 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] s_op(input int imm, input int rs2, input int rs1);
    logic [11:0] m = 12'(imm);
    return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_op(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] m = 13'(imm);
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), f3, m[4:1], m[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] j_op(input int imm, input int rd);
    logic [20:0] m = 21'(imm);
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'b1101111};
  endfunction

  rv_multicycle_core dut (.clk(clk), .rst(rst), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .wr_data(wr_data), .rd_data(rd_data), .mem_ready(mem_ready), .PC(pc), .halted(halted), .instret(instret));
  rv_multicycle_core #(.NUM_REGS(16)) dut16 (.clk(clk), .rst(rst), .mem_req(req16), .mem_wr(wr16), .mem_addr(addr16),
    .wr_data(wd16), .rd_data(rd16), .mem_ready(1'b1), .PC(pc16), .halted(halted16), .instret(ir16));

  assign rd16 = addr16 == 0 ? i_op(1, 0, 3'd0, 1, 7'h13) : r_op(7'h00, 2, 1, 3'd0, 17);
  assign mem_ready = mem_req && wcnt >= wait_n && !(stall_wr && mem_wr);
  assign rd_data = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (rst || !mem_req || mem_ready) begin
      wcnt <= 0;
      wait_n <= fixed_wait >= 0 ? fixed_wait : int'($urandom_range(0, 3));
    end else wcnt <= wcnt + 1;
    if (!rst && mem_req && mem_wr && mem_ready) mem[mem_addr[9:2]] = wr_data;
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (hold_p) chk("req_hold", {31'b0, mem_wr, mem_addr, wr_data}, hold_v);
    hold_p = mem_req && !mem_ready;
    hold_v = {31'b0, mem_wr, mem_addr, wr_data};
    if (mem_req && mem_wr && mem_addr == 32'h8 && wr_data == 32'd5) w8++;
    if (mem_req && mem_wr && mem_ready) begin
      st_a.push_back(mem_addr);
      st_d.push_back(wr_data);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start(input logic [31:0] p[$], input int w, input bit rnd);
    @(negedge clk);
    rst = 1;
    fixed_wait = w;
    foreach (mem[i]) mem[i] = (rnd && i >= 128) ? $urandom : 32'd0;
    foreach (p[i]) mem[i] = p[i];
    foreach (mem[i]) mm[i] = mem[i];
    @(negedge clk);
    rst = 0;
    hold_p = 0;
    w8 = 0;
    st_a.delete();
    st_d.delete();
  endtask

  task automatic run_to_halt(input int budget, output int cyc);
    cyc = 0;
    while (!halted && cyc < budget) begin
      step();
      cyc++;
    end
    chk("halt_reached", halted, 1);
  endtask

  function automatic bit m_alu(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y, output logic [31:0] r);
    r = 0;
    case (f3)
      3'd0: r = x + y;
      3'd2: r = $signed(x) < $signed(y) ? 32'd1 : 32'd0;
      3'd4: r = x ^ y;
      3'd6: r = x | y;
      3'd7: r = x & y;
      default: return 0;
    endcase
    return 1;
  endfunction

  // instruction-set level interpreter; cycle cost assumes a fixed wait count w per access
  task automatic model_run(input int w);
    logic [31:0] rg [32];
    foreach (rg[i]) rg[i] = 0;
    m_pc = 0;
    m_ret = 0;
    m_cyc = 0;
    m_sa.delete();
    m_sd.delete();
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] ins, x, y, ii, si, bi, ji, r, nxt, ea;
      logic [2:0] f3;
      logic [6:0] f7;
      bit ok, wbk;
      int cost;
      ins = mm[m_pc[9:2]];
      f3 = ins[14:12];
      f7 = ins[31:25];
      x = rg[ins[19:15]];
      y = rg[ins[24:20]];
      ii = {{20{ins[31]}}, ins[31:20]};
      si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      bi = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      ji = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      nxt = m_pc + 4;
      r = 0;
      ok = 0;
      wbk = 0;
      cost = 0;
      case (ins[6:0])
        7'h33: begin
          ok = m_alu(f3, x, y, r);
          if (f7 == 7'h20) begin
            ok = ok && f3 == 0;
            r = x - y;
          end else ok = ok && f7 == 0;
          wbk = 1;
          cost = 4 + w;
        end
        7'h13: begin
          ok = m_alu(f3, x, ii, r);
          wbk = 1;
          cost = 4 + w;
        end
        7'h03: begin
          ok = f3 == 2;
          ea = x + ii;
          r = mm[ea[9:2]];
          wbk = 1;
          cost = 5 + 2 * w;
        end
        7'h23: begin
          ok = f3 == 2;
          ea = (x + si) & ~32'd3;
          if (ok) begin
            mm[ea[9:2]] = y;
            m_sa.push_back(ea);
            m_sd.push_back(y);
          end
          cost = 4 + 2 * w;
        end
        7'h63: begin
          ok = f3 == 0;
          if (x == y) nxt = m_pc + bi;
          cost = 3 + w;
        end
        7'h6F: begin
          ok = 1;
          r = m_pc + 4;
          nxt = m_pc + ji;
          wbk = 1;
          cost = 4 + w;
        end
        default: ok = 0;
      endcase
      if (!ok) begin
        m_cyc += 2 + w;
        break;
      end
      if (wbk && ins[11:7] != 0) rg[ins[11:7]] = r;
      m_pc = nxt;
      m_ret++;
      m_cyc += cost;
    end
  endtask

  task automatic gen(output logic [31:0] p[$]);
    logic [2:0] f3s [5] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
    logic [31:0] bad [5];
    int body;
    bad = '{32'hFFFF_FFFF, r_op(7'h01, 2, 1, 3'd0, 3), i_op(0, 0, 3'd0, 1, 7'h03), b_op(8, 0, 0, 3'd1), i_op(1, 1, 3'd1, 1, 7'h13)};
    p.delete();
    body = 20 + $urandom_range(0, 20);
    for (int i = 0; i < body; i++) begin
      int rd = $urandom_range(0, 15), rs1 = $urandom_range(0, 15), rs2 = $urandom_range(0, 15);
      logic [2:0] f3 = f3s[$urandom_range(0, 4)];
      case ($urandom_range(0, 7))
        0, 1: p.push_back(r_op((f3 == 0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2, rs1, f3, rd));
        2, 3: p.push_back(i_op(int'($urandom_range(0, 4095)) - 2048, rs1, f3, rd, 7'h13));
        4: p.push_back(i_op(512 + 4 * $urandom_range(0, 63) + $urandom_range(0, 3), 0, 3'd2, rd, 7'h03));
        5: p.push_back(s_op(512 + 4 * $urandom_range(0, 63) + $urandom_range(0, 3), rs2, 0));
        6: p.push_back(b_op(4 * $urandom_range(1, 3), $urandom_range(0, 1) == 1 ? rs1 : rs2, rs1, 3'd0));
        default: p.push_back(j_op(4 * $urandom_range(1, 3), rd));
      endcase
    end
    for (int r = 1; r < 16; r++) p.push_back(s_op(768 + 4 * r, r, 0));
    p.push_back(bad[$urandom_range(0, 4)]);
  endtask

  initial begin
    logic [31:0] p[$];
    int cyc;
    // straight-line arithmetic, reset state, opcode 0x7F halt, RV32E register bound
    p = '{i_op(5, 0, 3'd0, 1, 7'h13), i_op(-3, 0, 3'd0, 2, 7'h13), r_op(7'h00, 2, 1, 3'd0, 3),
          s_op(32'h200, 3, 0), 32'h0000_007F};
    start(p, 0, 0);
    chk("rst_req", {mem_req, mem_wr}, 2'b10);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_pc_instret_halted", {pc, instret, 31'b0, halted}, 96'h0);
    chk("rst16_req_addr", {req16, addr16}, {1'b1, 32'h0});
    steps(11);
    chk("add_instret_11", instret, 2);
    step();
    chk("add_instret_12", instret, 3);
    chk("add_pc_12", pc, 32'hC);
    run_to_halt(100, cyc);
    chk("add_tail_cycles", cyc, 6);
    chk("add_x3", mem[128], 2);
    steps(5);
    chk("halt7f_state", {mem_req, pc, instret}, {1'b0, 32'h10, 32'd4});
    chk("rv32e_halt", {halted16, req16, pc16, ir16}, {1'b1, 1'b0, 32'h4, 32'd1});
    // beq taken backwards, beq not taken
    p = '{i_op(5, 0, 3'd0, 1, 7'h13), j_op(12, 0), 32'hFFFF_FFFF, j_op(12, 0), b_op(-4, 0, 0, 3'd0),
          32'hFFFF_FFFF, b_op(8, 0, 1, 3'd0), 32'hFFFF_FFFF};
    start(p, 0, 0);
    steps(8);
    chk("beq_pc_at", pc, 32'h10);
    steps(3);
    chk("beq_taken_pc", {pc, instret}, {32'hC, 32'd3});
    steps(4);
    chk("beq_jal_pc", pc, 32'h18);
    steps(3);
    chk("beq_fall_pc", {pc, instret}, {32'h1C, 32'd5});
    steps(2);
    chk("beq_halt", {halted, pc, instret}, {1'b1, 32'h1C, 32'd5});
    // jal link and x0 immutability
    p = '{j_op(32, 0), 0, 0, 0, 0, 0, 0, 0, j_op(16, 1), 0, 0, 0, i_op(7, 0, 3'd0, 0, 7'h13),
          s_op(32'h204, 1, 0), s_op(32'h208, 0, 0), 32'hFFFF_FFFF};
    start(p, 0, 0);
    mem[129] = 32'hDEAD_BEEF;
    mem[130] = 32'hDEAD_BEEF;
    steps(4);
    chk("jal_pc1", pc, 32'h20);
    steps(4);
    chk("jal_pc2", {pc, instret}, {32'h30, 32'd2});
    run_to_halt(100, cyc);
    chk("jal_link", mem[129], 32'h24);
    chk("x0_zero", mem[130], 0);
    chk("jal_end", {pc, instret}, {32'h3C, 32'd5});
    // store then load with three wait states per access
    p = '{i_op(5, 0, 3'd0, 1, 7'h13), j_op(16, 0), 32'h1111_1111, 0, 0, s_op(8, 1, 0),
          i_op(8, 0, 3'd2, 4, 7'h03), s_op(32'h200, 4, 0), 32'hFFFF_FFFF};
    start(p, 3, 0);
    run_to_halt(200, cyc);
    chk("wait_cycles", cyc, 50);
    chk("sw_hold_cycles", w8, 4);
    chk("sw_mem", mem[2], 5);
    chk("lw_x4", mem[128], 5);
    chk("wait_instret", instret, 5);
    // reset while a store is pending
    p = '{i_op(9, 0, 3'd0, 1, 7'h13), s_op(32'h200, 1, 0), 32'hFFFF_FFFF};
    stall_wr = 1;
    start(p, 0, 0);
    for (int i = 0; i < 20 && !mem_wr; i++) step();
    chk("st_pending", {mem_req, mem_wr, mem_ready}, 3'b110);
    chk("st_pending_instret", instret, 1);
    steps(3);
    rst = 1;
    @(negedge clk);
    rst = 0;
    hold_p = 0;
    chk("rst_mid_req", {mem_req, mem_wr, mem_addr}, {2'b10, 32'h0});
    chk("rst_mid_pc_instret", {pc, instret}, 64'h0);
    chk("rst_mid_nostore", mem[128], 0);
    steps(4);
    chk("rst_mid_restart", instret, 1);
    stall_wr = 0;
    // random programs against the ISA model
    for (int t = 0; t < 30; t++) begin
      int w;
      w = t % 4 == 3 ? -1 : t % 3;
      gen(p);
      start(p, w, 1);
      model_run(w);
      run_to_halt(3000, cyc);
      chk("rnd_pc", pc, m_pc);
      chk("rnd_instret", instret, m_ret);
      chk("rnd_nstores", st_a.size(), m_sa.size());
      for (int i = 0; i < m_sa.size() && i < st_a.size(); i++) begin
        chk("rnd_st_addr", st_a[i], m_sa[i]);
        chk("rnd_st_data", st_d[i], m_sd[i]);
      end
      if (w >= 0) chk("rnd_cycles", cyc, m_cyc);
      steps(3);
      chk("rnd_frozen", {mem_req, halted, pc, instret}, {2'b01, m_pc, m_ret});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
